mux_scan_ctrl: RTL and testbench

//  Select controller for the 4:1 nibble display mux (16-bit SW -> 4-bit LED; sel 0/1/2 = SW[3:0]/[7:4]/[11:8],
//  sel 3 = blank 0000). Replaces the raw SW[15:14] select with a sequenced select.

---
 rtl/mux_scan_ctrl_pkg.sv | 27 ++
 rtl/mux_scan_ctrl_dwell_timer.sv | 41 ++++
 rtl/mux_scan_ctrl.sv | 115 +++++++++++
 tb/tb_mux_scan_ctrl.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/mux_scan_ctrl_pkg.sv
// Shared constants for the nibble display mux select controller.
// Latency: n/a (definitions only).
// Backpressure: n/a (definitions only).
//
// Contents: blank select code, channel count, FSM state encodings,
// channel advance helper and dwell counter width helper.
package mux_scan_ctrl_pkg;

  localparam logic [1:0] SEL_BLANK = 2'b11;
  localparam int         NUM_CH    = 3;

  localparam logic [1:0] ST_BLANK  = 2'd0;
  localparam logic [1:0] ST_MANUAL = 2'd1;
  localparam logic [1:0] ST_SCAN   = 2'd2;
  localparam logic [1:0] ST_HOLD   = 2'd3;

  // Channel rotation 0->1->2->0; the blank code never comes out of here.
  function automatic logic [1:0] next_ch(input logic [1:0] cur);
    return (cur >= 2'(NUM_CH - 1)) ? 2'd0 : cur + 2'd1;
  endfunction

  // Width needed to count 0..dwell-1, never narrower than one bit.
  function automatic int cnt_width(input int dwell);
    return (dwell > 1) ? $clog2(dwell) : 1;
  endfunction

endpackage

// File: rtl/mux_scan_ctrl_dwell_timer.sv
// Dwell timer: counts cycles a channel has been shown, flags the last one.
// Latency: expired is combinational from the registered count.
// Backpressure: none; clr wins over run, !run freezes the count.
//
// Ports:
//   clk, rst  clock and asynchronous active-high reset
//   clr       force count to 0 on the next edge
//   run       increment the count (wraps to 0 after DWELL-1)
//   expired   count currently equals DWELL-1
module dwell_timer
  import mux_scan_ctrl_pkg::*;
#(
  parameter int DWELL = 100_000_000
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic run,
  output logic expired
);

  localparam int               CNT_W = cnt_width(DWELL);
  localparam logic [CNT_W-1:0] LAST  = CNT_W'(DWELL - 1);

  logic [CNT_W-1:0] cnt;

  assign expired = (cnt == LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (run) begin
      // The top normally clears on expiry; wrapping here as well keeps the
      // count inside 0..DWELL-1 regardless of how the timer is driven.
      cnt <= expired ? '0 : cnt + 1'b1;
    end
  end

endmodule

// File: rtl/mux_scan_ctrl.sv
// Select controller for the 4:1 nibble display mux (manual / auto scan / hold).
// Latency: all outputs registered, one cycle from inputs.
// Backpressure: none; inputs are sampled every cycle.
//
// Ports:
//   clk, rst   clock and asynchronous active-high reset
//   en         0 forces blank (sel=3)
//   mode       0 manual, 1 auto scan
//   man_sel    manual channel select (3 = blank, passed through)
//   pause      level, freezes auto scan
//   step       single-cycle pulse, advance one channel in scan/hold
//   sel        registered mux select
//   scanning   1 while in SCAN or HOLD
//   wrap       one-cycle pulse with the sel 2->0 advance
module mux_scan_ctrl
  import mux_scan_ctrl_pkg::*;
#(
  parameter int DWELL = 100_000_000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic       mode,
  input  logic [1:0] man_sel,
  input  logic       pause,
  input  logic       step,
  output logic [1:0] sel,
  output logic       scanning,
  output logic       wrap
);

  logic [1:0] state;
  logic [1:0] state_nxt;
  logic [1:0] sel_nxt;
  logic       wrap_nxt;
  logic       adv;
  logic       tmr_clr;
  logic       tmr_run;
  logic       expired;
  logic       in_scan;

  assign in_scan = (state == ST_SCAN) || (state == ST_HOLD);

  dwell_timer #(
    .DWELL (DWELL)
  ) u_timer (
    .clk     (clk),
    .rst     (rst),
    .clr     (tmr_clr),
    .run     (tmr_run),
    .expired (expired)
  );

  // Decisions are taken in priority order: enable, mode, pause, step, expiry.
  always_comb begin
    state_nxt = state;
    sel_nxt   = sel;
    wrap_nxt  = 1'b0;
    adv       = 1'b0;
    tmr_clr   = 1'b0;
    tmr_run   = 1'b0;

    if (!en) begin
      // Dropping enable discards the dwell count; re-entry starts at ch 0.
      state_nxt = ST_BLANK;
      sel_nxt   = SEL_BLANK;
      tmr_clr   = 1'b1;
    end else if (!mode) begin
      // Manual (also the exit from scan/hold): follow man_sel immediately.
      state_nxt = ST_MANUAL;
      sel_nxt   = man_sel;
      tmr_clr   = 1'b1;
    end else if (!in_scan) begin
      // Entering auto scan from blank or manual.
      state_nxt = ST_SCAN;
      sel_nxt   = 2'd0;
      tmr_clr   = 1'b1;
    end else if (pause) begin
      // The pausing edge itself freezes everything, step included; once
      // held, a step moves exactly one channel.
      state_nxt = ST_HOLD;
      adv       = (state == ST_HOLD) && step;
    end else begin
      // Scanning, or leaving hold: the count resumes on this same edge.
      state_nxt = ST_SCAN;
      if (step || expired) begin
        adv = 1'b1;
      end else begin
        tmr_run = 1'b1;
      end
    end

    // A step coinciding with expiry funnels into this single advance.
    if (adv) begin
      sel_nxt  = next_ch(sel);
      wrap_nxt = (sel == 2'(NUM_CH - 1));
      tmr_clr  = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= ST_BLANK;
      sel      <= SEL_BLANK;
      scanning <= 1'b0;
      wrap     <= 1'b0;
    end else begin
      state    <= state_nxt;
      sel      <= sel_nxt;
      scanning <= (state_nxt == ST_SCAN) || (state_nxt == ST_HOLD);
      wrap     <= wrap_nxt;
    end
  end

endmodule

// File: tb/tb_mux_scan_ctrl.sv
// Self-checking bench for mux_scan_ctrl with DWELL=4: directed steps, then
// random inputs against a behavioural model of the select rules.
module tb_mux_scan_ctrl;

  localparam int DW = 4;

  logic       clk = 1'b0;
  logic       rst;
  logic       en;
  logic       mode;
  logic [1:0] man_sel;
  logic       pause;
  logic       step;
  logic [1:0] sel;
  logic       scanning;
  logic       wrap;

  int errors = 0;
  int checks = 0;

  // Reference model: current channel, position inside its dwell, whether
  // auto scan is active, whether it is held, and the expected wrap pulse.
  int m_sel;
  int m_cnt;
  bit m_on;
  bit m_hold;
  bit m_wrap;

  always #5 clk = ~clk;

  mux_scan_ctrl #(.DWELL(DW)) dut (
    .clk      (clk),
    .rst      (rst),
    .en       (en),
    .mode     (mode),
    .man_sel  (man_sel),
    .pause    (pause),
    .step     (step),
    .sel      (sel),
    .scanning (scanning),
    .wrap     (wrap)
  );

  function automatic void model_reset();
    m_sel  = 3;
    m_cnt  = 0;
    m_on   = 0;
    m_hold = 0;
    m_wrap = 0;
  endfunction

  // One clock edge of the select rules, applied to the sampled inputs.
  function automatic void model_edge();
    bit advance;
    advance = 0;
    m_wrap  = 0;
    if (!en) begin
      m_on = 0; m_hold = 0; m_sel = 3; m_cnt = 0;
    end else if (!mode) begin
      m_on = 0; m_hold = 0; m_sel = int'(man_sel); m_cnt = 0;
    end else if (!m_on) begin
      m_on = 1; m_hold = 0; m_sel = 0; m_cnt = 0;
    end else if (pause) begin
      advance = m_hold && step;
      m_hold  = 1;
    end else begin
      m_hold = 0;
      if (step || m_cnt == DW - 1) advance = 1;
      else m_cnt = m_cnt + 1;
    end
    if (advance) begin
      m_wrap = (m_sel == 2);
      m_sel  = (m_sel + 1) % 3;
      m_cnt  = 0;
    end
  endfunction

  task automatic expect_out(input string tag, input logic [1:0] es,
                            input logic esc, input logic ew);
    checks++;
    assert (sel === es) else begin
      errors++;
      $error("FAIL %s sel got=%0d exp=%0d", tag, sel, es);
    end
    checks++;
    assert (scanning === esc) else begin
      errors++;
      $error("FAIL %s scanning got=%0b exp=%0b", tag, scanning, esc);
    end
    checks++;
    assert (wrap === ew) else begin
      errors++;
      $error("FAIL %s wrap got=%0b exp=%0b", tag, wrap, ew);
    end
  endtask

  task automatic check_model(input string tag);
    expect_out(tag, 2'(m_sel), m_on, m_wrap);
  endtask

  // Inputs change only at negedge; the model steps at posedge; outputs are
  // compared at the following negedge.
  task automatic tick();
    @(posedge clk);
    model_edge();
    @(negedge clk);
  endtask

  task automatic tick_chk(input string tag);
    tick();
    check_model(tag);
  endtask

  task automatic run_until(input int s, input int c, input string tag);
    bit found;
    found = 0;
    for (int i = 0; i < 20; i++) begin
      if (m_sel == s && m_cnt == c) begin
        found = 1;
        break;
      end
      tick_chk(tag);
    end
    checks++;
    assert (found) else begin
      errors++;
      $error("FAIL %s reach sel=%0d cnt=%0d got=timeout exp=reached", tag, s, c);
    end
  endtask

  initial begin : stim
    logic [1:0] exp_seq [13];
    exp_seq = '{2'd0, 2'd0, 2'd0, 2'd0, 2'd1, 2'd1, 2'd1, 2'd1,
                2'd2, 2'd2, 2'd2, 2'd2, 2'd0};

    rst = 1'b0; en = 1'b0; mode = 1'b0; man_sel = 2'd0; pause = 1'b0; step = 1'b0;
    model_reset();

    // 1. reset and disabled state
    #2 rst = 1'b1;
    #1 expect_out("reset", 2'd3, 1'b0, 1'b0);
    @(negedge clk) rst = 1'b0;
    tick_chk("en0");
    tick_chk("en0");
    expect_out("en0_direct", 2'd3, 1'b0, 1'b0);

    // 2. manual select, including the blank code
    en = 1'b1; man_sel = 2'd1;
    tick();
    expect_out("man1", 2'd1, 1'b0, 1'b0);
    man_sel = 2'd3;
    tick();
    expect_out("man3", 2'd3, 1'b0, 1'b0);

    // 3. auto scan sequence with wrap
    mode = 1'b1;
    for (int i = 0; i < 13; i++) begin
      tick();
      expect_out("scan_seq", exp_seq[i], 1'b1, (i == 12) ? 1'b1 : 1'b0);
    end

    // 4. step mid-dwell, then step on the last dwell cycle
    tick_chk("pre_step");
    step = 1'b1;
    tick();
    expect_out("step_cnt1", 2'd1, 1'b1, 1'b0);
    step = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      expect_out("full_dwell", 2'd1, 1'b1, 1'b0);
    end
    tick();
    expect_out("dwell_end", 2'd2, 1'b1, 1'b0);
    repeat (3) tick_chk("to_cnt3");
    step = 1'b1;
    tick();
    expect_out("step_expiry", 2'd0, 1'b1, 1'b1);
    step = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      expect_out("single_adv", 2'd0, 1'b1, 1'b0);
    end
    tick_chk("after_single");

    // 5. pause, step while held, resume
    run_until(1, 2, "seek_pause");
    pause = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      expect_out("hold", 2'd1, 1'b1, 1'b0);
    end
    step = 1'b1;
    tick();
    expect_out("hold_step", 2'd2, 1'b1, 1'b0);
    step = 1'b0;
    tick_chk("hold_after_step");
    pause = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      expect_out("resume", 2'd2, 1'b1, 1'b0);
    end
    tick();
    expect_out("resume_adv", 2'd0, 1'b1, 1'b1);

    // 6. enable drop, restart, exit to manual
    run_until(2, 1, "seek_en");
    en = 1'b0;
    tick();
    expect_out("en_drop", 2'd3, 1'b0, 1'b0);
    en = 1'b1;
    tick();
    expect_out("restart", 2'd0, 1'b1, 1'b0);
    tick_chk("restart_run");
    mode = 1'b0; man_sel = 2'd2;
    tick();
    expect_out("to_manual", 2'd2, 1'b0, 1'b0);

    // asynchronous reset in the middle of a scan
    mode = 1'b1;
    repeat (6) tick_chk("pre_rst");
    #2 rst = 1'b1;
    #1 expect_out("async_rst", 2'd3, 1'b0, 1'b0);
    model_reset();
    @(negedge clk) rst = 1'b0;
    tick_chk("post_rst");

    // random traffic against the model
    for (int i = 0; i < 1500; i++) begin
      en      = ($urandom_range(0, 39) != 0);
      if ($urandom_range(0, 29) == 0) mode = ~mode;
      if ($urandom_range(0, 9) == 0) pause = ~pause;
      step    = ($urandom_range(0, 5) == 0);
      man_sel = 2'($urandom_range(0, 3));
      tick_chk("rand");
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
